// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues requests; the slave side is the subtractor itself.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  diff,
        input  borrow
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output diff,
        output borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// built from a single full-subtractor cell and a borrow flop.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bin_q, bin_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;

    // Full-subtractor cell on the current LSBs.
    logic d_bit;
    logic bout;
    assign d_bit = ra_q[0] ^ rb_q[0] ^ bin_q;
    assign bout  = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & bin_q);

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                ra_d             = ra_q >> 1;
                rb_d             = rb_q >> 1;
                // New bit enters at the MSB so the result is aligned after WIDTH shifts.
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = d_bit;
                bin_d            = bout;
                cnt_d            = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    diff_d   = res_d;
                    borrow_d = bout;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ra_q     <= '0;
            rb_q     <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q == StRun);
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

    // done is only raised on the transition back to idle.
    done_not_busy_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.done && bus.busy));
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH = 8) with
// hand-written sequences for ignored starts, mid-run reset and back-to-back ops.
module tb_serial_subtractor;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_diff;
        logic       exp_borrow;
    } vec_t;

    vec_t vecs [0:5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse start at E0, then watch up to 3*WIDTH edges (sampled 1 after each edge).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_diff, input logic exp_borrow);
        int done_at;
        int busy_cnt;
        int done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        done_at   = -1;
        busy_cnt  = 0;
        done_cnt  = 0;
        for (int k = 1; k <= 3 * WIDTH; k++) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    check("diff", int'(bus.diff), int'(exp_diff));
                    check("borrow", int'(bus.borrow), int'(exp_borrow));
                    check("busy_at_done", int'(bus.busy), 0);
                end
            end
        end
        check("done_latency", done_at, WIDTH);
        check("busy_cycles", busy_cnt, WIDTH);
        check("done_pulses", done_cnt, 1);
        check("diff_held", int'(bus.diff), int'(exp_diff));
    endtask

    initial begin
        int done_cnt;
        int idx1;
        int idx2;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       b1;
        logic       b2;

        n_checks  = 0;
        n_fail    = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0] = '{a: 8'd200, b: 8'd100, exp_diff: 8'd100, exp_borrow: 1'b0};
        vecs[1] = '{a: 8'd5,   b: 8'd10,  exp_diff: 8'd251, exp_borrow: 1'b1};
        vecs[2] = '{a: 8'd0,   b: 8'd1,   exp_diff: 8'd255, exp_borrow: 1'b1};
        vecs[3] = '{a: 8'd0,   b: 8'd0,   exp_diff: 8'd0,   exp_borrow: 1'b0};
        vecs[4] = '{a: 8'd255, b: 8'd255, exp_diff: 8'd0,   exp_borrow: 1'b0};
        vecs[5] = '{a: 8'd255, b: 8'd0,   exp_diff: 8'd255, exp_borrow: 1'b0};

        rst_n = 1'b0;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_diff", int'(bus.diff), 0);
        check("rst_borrow", int'(bus.borrow), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow);
        end

        // Second start during RUN must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd50;
        bus.b     = 8'd20;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_cnt  = 0;
        idx1      = -1;
        for (int k = 1; k <= 3 * WIDTH; k++) begin
            if (k == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'd1;
                bus.b     = 8'd2;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                done_cnt++;
                if (idx1 < 0) idx1 = k;
            end
        end
        check("ign_done_pulses", done_cnt, 1);
        check("ign_latency", idx1, WIDTH);
        check("ign_diff", int'(bus.diff), 30);
        check("ign_borrow", int'(bus.borrow), 0);

        // Asynchronous reset mid-operation clears everything at once.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_diff", int'(bus.diff), 0);
        check("abort_borrow", int'(bus.borrow), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_cnt++;
        end
        check("abort_no_activity", done_cnt, 0);
        run_op(8'd7, 8'd7, 8'd0, 1'b0);

        // start held high: operations every WIDTH+1 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd10;
        bus.b     = 8'd4;
        @(posedge clk);
        #1;
        bus.a = 8'd4;
        bus.b = 8'd10;
        idx1  = -1;
        idx2  = -1;
        d1    = '0;
        d2    = '0;
        b1    = 1'b0;
        b2    = 1'b0;
        for (int k = 1; k <= 4 * WIDTH; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (idx1 < 0) begin
                    idx1 = k;
                    d1   = bus.diff;
                    b1   = bus.borrow;
                end else if (idx2 < 0) begin
                    idx2      = k;
                    d2        = bus.diff;
                    b2        = bus.borrow;
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        check("b2b_first_at", idx1, WIDTH);
        check("b2b_gap", idx2 - idx1, WIDTH + 1);
        check("b2b_diff1", int'(d1), 6);
        check("b2b_borrow1", int'(b1), 0);
        check("b2b_diff2", int'(d2), 250);
        check("b2b_borrow2", int'(b2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
